// File: rtl/pipe_stage_reg_pkg.sv
// Shared Y86 pipeline constants and bundle sizing for the stage registers.
// Used by decode/execute as well as every pipe_stage_reg instance.
package pipe_stage_reg_pkg;

    localparam int         DEF_WORD_W    = 32;
    localparam int         DEF_BYTE_W    = 8;
    localparam logic [7:0] Y86_NOP_ICODE = 8'h01;
    localparam logic [7:0] Y86_RNONE     = 8'h0F;

    // Packed as {icode, rA, rB, dstE, valA, valP, valE}.
    function automatic int bundle_w(input int byte_w, input int word_w);
        return 4 * byte_w + 3 * word_w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// Single valid+bundle register; clear returns it to the bubble value.
// Latency: 1 cycle from load to q.
// Backpressure: none here; the parent decides when to load or clear.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int             BW     = bundle_w(DEF_BYTE_W, DEF_WORD_W),
    parameter logic [BW-1:0]  BUBBLE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [BW-1:0] d,
    output logic          vld,
    output logic [BW-1:0] q
);

    // Clear wins over load so a flush can never leave a live bundle behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= BUBBLE;
        end else if (clear) begin
            vld <= 1'b0;
            q   <= BUBBLE;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic Y86 pipeline stage register with a 2-entry skid buffer, flush and perf counters.
// Latency: 1 cycle in->out when unstalled; one bundle per cycle sustained.
// Backpressure: in_ready is registered (!skid valid); no combinational path from out_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int         WORD_W    = DEF_WORD_W,
    parameter int         BYTE_W    = DEF_BYTE_W,
    parameter logic [7:0] NOP_ICODE = Y86_NOP_ICODE,
    parameter logic [7:0] RNONE     = Y86_RNONE,
    parameter int         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_icode,
    input  logic [BYTE_W-1:0] in_rA,
    input  logic [BYTE_W-1:0] in_rB,
    input  logic [BYTE_W-1:0] in_dstE,
    input  logic [WORD_W-1:0] in_valA,
    input  logic [WORD_W-1:0] in_valP,
    input  logic [WORD_W-1:0] in_valE,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_icode,
    output logic [BYTE_W-1:0] out_rA,
    output logic [BYTE_W-1:0] out_rB,
    output logic [BYTE_W-1:0] out_dstE,
    output logic [WORD_W-1:0] out_valA,
    output logic [WORD_W-1:0] out_valP,
    output logic [WORD_W-1:0] out_valE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int                BW        = bundle_w(BYTE_W, WORD_W);
    localparam logic [BYTE_W-1:0] BUB_ICODE = BYTE_W'(NOP_ICODE);
    localparam logic [BYTE_W-1:0] BUB_REG   = BYTE_W'(RNONE);
    localparam logic [BW-1:0]     BUBBLE    = {BUB_ICODE, BUB_REG, BUB_REG, BUB_REG,
                                               {(3 * WORD_W){1'b0}}};

    logic          m_vld, s_vld;
    logic [BW-1:0] m_q, s_q, m_d, in_bus;
    logic          m_load, m_clr, s_load, s_clr;
    logic          in_fire, out_fire;

    assign in_bus    = {in_icode, in_rA, in_rB, in_dstE, in_valA, in_valP, in_valE};
    assign in_ready  = ~s_vld;
    assign out_valid = m_vld;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_vld & out_ready;

    assign {out_icode, out_rA, out_rB, out_dstE, out_valA, out_valP, out_valE} = m_q;

    always_comb begin
        m_load = 1'b0;
        m_clr  = 1'b0;
        m_d    = in_bus;
        s_load = 1'b0;
        s_clr  = 1'b0;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else if (!m_vld) begin
            m_load = in_fire;
        end else if (out_fire) begin
            if (s_vld) begin
                // Skid drains first to keep FIFO order; in_ready is low so no input lands.
                m_load = 1'b1;
                m_d    = s_q;
                s_clr  = 1'b1;
            end else if (in_fire) begin
                m_load = 1'b1;
            end else begin
                m_clr = 1'b1;
            end
        end else begin
            s_load = in_fire;
        end
    end

    pipe_slot #(.BW(BW), .BUBBLE(BUBBLE)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (m_load),
        .clear (m_clr),
        .d     (m_d),
        .vld   (m_vld),
        .q     (m_q)
    );

    pipe_slot #(.BW(BW), .BUBBLE(BUBBLE)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s_load),
        .clear (s_clr),
        .d     (in_bus),
        .vld   (s_vld),
        .q     (s_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (m_vld && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a 2-deep queue model of the stage predicts every output cycle.
module tb_pipe_stage_reg;

    localparam int           SAT     = 15;
    localparam logic [127:0] BUB_EXP = {8'h01, 8'h0F, 8'h0F, 8'h0F, 96'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [7:0]  in_icode = '0, in_rA = '0, in_rB = '0, in_dstE = '0;
    logic [31:0] in_valA = '0, in_valP = '0, in_valE = '0;
    logic [7:0]  out_icode, out_rA, out_rB, out_dstE;
    logic [31:0] out_valA, out_valP, out_valE;
    logic [3:0]  stall_cnt, bubble_cnt;
    logic [127:0] out_bus;

    assign out_bus = {out_icode, out_rA, out_rB, out_dstE, out_valA, out_valP, out_valE};

    pipe_stage_reg #(.WORD_W(32), .BYTE_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB), .in_dstE(in_dstE),
        .in_valA(in_valA), .in_valP(in_valP), .in_valE(in_valE),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_rA(out_rA), .out_rB(out_rB), .out_dstE(out_dstE),
        .out_valA(out_valA), .out_valP(out_valP), .out_valE(out_valE),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Wide-word / narrow-id instance.
    logic        w_in_valid = 1'b0, w_in_ready, w_out_valid;
    logic [3:0]  w_in_icode = '0, w_in_rA = '0, w_in_rB = '0, w_in_dstE = '0;
    logic [63:0] w_in_valA = '0, w_in_valP = '0, w_in_valE = '0;
    logic [3:0]  w_out_icode, w_out_rA, w_out_rB, w_out_dstE;
    logic [63:0] w_out_valA, w_out_valP, w_out_valE;
    logic [15:0] w_stall_cnt, w_bubble_cnt;

    pipe_stage_reg #(.WORD_W(64), .BYTE_W(4), .CNT_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_icode(w_in_icode), .in_rA(w_in_rA), .in_rB(w_in_rB), .in_dstE(w_in_dstE),
        .in_valA(w_in_valA), .in_valP(w_in_valP), .in_valE(w_in_valE),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_icode(w_out_icode), .out_rA(w_out_rA), .out_rB(w_out_rB), .out_dstE(w_out_dstE),
        .out_valA(w_out_valA), .out_valP(w_out_valP), .out_valE(w_out_valE),
        .stall_cnt(w_stall_cnt), .bubble_cnt(w_bubble_cnt)
    );

    int checks = 0;
    int failures = 0;
    logic [127:0] qm[$];
    int exp_stall = 0;
    int exp_bubble = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 256'(out_valid), 256'(qm.size() > 0));
        chk("in_ready", 256'(in_ready), 256'(qm.size() < 2));
        chk("bundle", 256'(out_bus), 256'((qm.size() > 0) ? qm[0] : BUB_EXP));
        chk("stall_cnt", 256'(stall_cnt), 256'(exp_stall));
        chk("bubble_cnt", 256'(bubble_cnt), 256'(exp_bubble));
    endtask

    // One cycle: check the current state, drive inputs, advance the model to the next edge.
    task automatic step(input logic iv, input logic fl, input logic ordy, input logic [7:0] ic);
        logic [127:0] b;
        logic         rdy_e, vld_e;
        @(negedge clk);
        compare_all();
        b = {ic, 8'($urandom), 8'($urandom), 8'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        {in_icode, in_rA, in_rB, in_dstE, in_valA, in_valP, in_valE} = b;
        in_valid  = iv;
        flush     = fl;
        out_ready = ordy;
        rdy_e = (qm.size() < 2);
        vld_e = (qm.size() > 0);
        if (vld_e && !ordy && exp_stall < SAT) exp_stall++;
        if (fl && exp_bubble < SAT) exp_bubble++;
        if (fl) begin
            qm.delete();
        end else begin
            if (vld_e && ordy) void'(qm.pop_front());
            if (iv && rdy_e) qm.push_back(b);
        end
    endtask

    task automatic reset_now();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_icode", 256'(out_icode), 256'(8'h01));
        chk("rst_dstE", 256'(out_dstE), 256'(8'h0F));
        chk("rst_stall", 256'(stall_cnt), 256'(0));
        chk("rst_bubble", 256'(bubble_cnt), 256'(0));
        qm.delete();
        exp_stall = 0;
        exp_bubble = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        reset_now();

        // Streaming 3,4,5 with out_ready held high.
        step(1, 0, 1, 8'd3);
        step(1, 0, 1, 8'd4);
        step(1, 0, 1, 8'd5);
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);

        // Back-pressure: M=3, push 4 into skid, then drain.
        step(1, 0, 0, 8'd3);
        step(1, 0, 0, 8'd4);
        step(0, 0, 0, 8'd0);
        step(0, 0, 0, 8'd0);
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);

        // Mixed traffic with random back-pressure.
        for (int i = 0; i < 40; i++)
            step(1'($urandom), 1'b0, 1'($urandom), 8'(8'h10 + i));
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);

        // Reset with both slots full.
        step(1, 0, 0, 8'd6);
        step(1, 0, 0, 8'd7);
        step(0, 0, 0, 8'd0);
        reset_now();
        step(0, 0, 1, 8'd0);

        // Flush with M=6, S=7 and a concurrent input 8.
        step(1, 0, 0, 8'd6);
        step(1, 0, 0, 8'd7);
        step(1, 1, 0, 8'd8);
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);

        // Saturation of the 4-bit stall counter.
        step(1, 0, 0, 8'd9);
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 8'd0);
        @(negedge clk);
        chk("stall_sat", 256'(stall_cnt), 256'(SAT));
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd0);

        // Width sweep on the 64/4 instance.
        @(negedge clk);
        w_in_valid = 1'b1;
        w_in_icode = 4'h3;
        w_in_rA    = 4'h2;
        w_in_rB    = 4'h5;
        w_in_dstE  = 4'h7;
        w_in_valA  = 64'h0123_4567_89AB_CDEF;
        w_in_valP  = 64'hFEDC_BA98_7654_3210;
        w_in_valE  = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        w_in_valid = 1'b0;
        chk("w_valid", 256'(w_out_valid), 256'(1));
        chk("w_valE", 256'(w_out_valE), 256'(64'hDEADBEEF_CAFEF00D));
        chk("w_valA", 256'(w_out_valA), 256'(64'h0123_4567_89AB_CDEF));
        chk("w_dstE", 256'(w_out_dstE), 256'(4'h7));
        @(negedge clk);
        chk("w_bub_valid", 256'(w_out_valid), 256'(0));
        chk("w_bub_dstE", 256'(w_out_dstE), 256'(4'hF));
        chk("w_bub_icode", 256'(w_out_icode), 256'(4'h1));
        chk("w_bub_valE", 256'(w_out_valE), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
